fp_sqrt_param: RTL and testbench
================================

FP_SQRT_PARAM -- requirements
Module: fp_sqrt_param

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (>=3).
REQ-002 SHALL have parameter MAN_W, default 7, stored fraction width (>=2); word width W = 1+EXP_W+MAN_W (default 16, bfloat16 layout).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sqrt_start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port num_i  input  W  operand {sign, exp, frac}; captured on the accepting edge.
REQ-007 SHALL have port busy_o  output  1  high from accept until the cycle valid_o is high, inclusive.
REQ-008 SHALL have port num_o  output  W  result; registered; held until the next valid_o.
REQ-009 SHALL have port error  output  1  invalid-operation flag; qualified by valid_o.
REQ-010 SHALL have port valid_o  output  1  single-cycle result strobe.

Function
REQ-011 SHALL implement FSM IDLE -> NORM -> ITER -> ROUND -> DONE -> IDLE; specials take IDLE -> DONE.
REQ-012 IDLE with sqrt_start=1 SHALL capture num_i and go to NORM, or to DONE if the operand is special.
REQ-013 sqrt_start while busy_o=1 SHALL be ignored; the in-flight operation SHALL be unaffected.
REQ-014 Specials: exp=0 (zero or subnormal, flushed) -> signed zero of the same sign, error=0; +Inf -> +Inf; NaN -> canonical quiet NaN (sign 0, exp all ones, frac MSB 1, rest 0), error=0; negative nonzero non-NaN (incl. -Inf) -> canonical NaN, error=1.
REQ-015 NORM SHALL form unbiased e = exp-bias (bias = 2^(EXP_W-1)-1), significand 1.frac, shifted left one bit if e is odd; result exponent = floor(e/2)+bias.
REQ-016 ITER SHALL run restoring digit-recurrence square root, one result bit per cycle, for exactly MAN_W+2 cycles (MAN_W+1 significand bits plus guard), using an iteration counter of ceil(log2(MAN_W+3)) bits.
REQ-017 ROUND SHALL apply round-to-nearest-even using guard and sticky (remainder nonzero); mantissa carry-out SHALL increment the result exponent and clear the fraction.
REQ-018 Normal-operand latency SHALL be MAN_W+4 cycles from the accepting edge to the edge that raises valid_o (11 at defaults); special latency SHALL be 1 cycle.
REQ-019 valid_o SHALL be high for exactly one cycle (DONE); a new sqrt_start SHALL be acceptable in the following cycle.
REQ-020 Result exponent SHALL never overflow or underflow for normal positive inputs; no further flags SHALL exist.

Reset
REQ-021 rst_n low SHALL immediately force state IDLE, counter 0, busy_o 0, valid_o 0, error 0, num_o 0, regardless of clock.
REQ-022 Reset asserted mid-operation SHALL abort it with no valid_o; the first edge after release SHALL be able to accept sqrt_start.

Configuration
REQ-023 Macro FP_SQRT_ROUND_EN defined: ROUND state and RNE per REQ-017 present.
REQ-024 FP_SQRT_ROUND_EN undefined: ROUND state omitted, result truncated (guard and sticky dropped), normal latency MAN_W+3; special handling unchanged.

Structure
REQ-025 Package fp_sqrt_pkg SHALL hold the state enum typedef, the bias function of EXP_W, and the canonical-NaN constant function of EXP_W/MAN_W.
REQ-026 Special-operand decoding SHALL be a combinational sub-module fp_sqrt_classify (outputs: is_zero, is_inf, is_nan, is_neg).
REQ-027 Datapath registers SHALL size to MAN_W+4 bits for radicand/remainder and MAN_W+2 for the root; no fixed 8-bit widths.

Verification (defaults unless stated)
REQ-028 num_i=0x4080 (4.0) -> num_o=0x4000, error=0, valid_o 11 cycles after accept; 0x4110 (9.0) -> 0x4040.
REQ-029 num_i=0x4000 (2.0) -> num_o=0x3FB5, error=0; 0x3F80 (1.0) -> 0x3F80.
REQ-030 num_i=0xBF80 (-1.0) -> num_o=0x7FC0, error=1, valid_o 1 cycle after accept; 0x0000 -> 0x0000, error=0; 0x8000 -> 0x8000, error=0; 0x7F80 -> 0x7F80.
REQ-031 sqrt_start with 0x4080 then sqrt_start with 0x4110 three cycles later -> single result 0x4000; second request ignored; back-to-back accept in cycle after valid_o succeeds.
REQ-032 rst_n low at ITER cycle 4 -> busy_o, valid_o drop immediately, no valid_o ever for that operand; next request after release completes normally.
REQ-033 Random sweep over all 2^16 bfloat16 inputs, both FP_SQRT_ROUND_EN settings, and EXP_W=5/MAN_W=10 -> match reference model bit-exactly.

Source files
------------

// File: rtl/fp_sqrt_pkg.sv
// Shared state type and format helpers for the parameterised floating-point square root.
// Build option FP_SQRT_ROUND_EN adds the ROUND state (round-to-nearest-even); otherwise results truncate.
package fp_sqrt_pkg;

`ifdef FP_SQRT_ROUND_EN
  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ITER, S_ROUND, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ITER, S_DONE} state_t;
`endif

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return (ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_sqrt_classify.sv
// Combinational special-operand decode for fp_sqrt_param (subnormals count as zero).
module fp_sqrt_classify #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic [EXP_W+MAN_W:0] num,
  output logic                 is_zero,
  output logic                 is_inf,
  output logic                 is_nan,
  output logic                 is_neg
);
  import fp_sqrt_pkg::*;

  logic exp_max;
  logic frac_nz;

  assign exp_max = &num[EXP_W+MAN_W-1:MAN_W];
  assign frac_nz = |num[MAN_W-1:0];
  assign is_zero = ~|num[EXP_W+MAN_W-1:MAN_W];
  assign is_inf  = exp_max & ~frac_nz;
  assign is_nan  = exp_max & frac_nz;
  assign is_neg  = num[EXP_W+MAN_W];

endmodule

// File: rtl/fp_sqrt_param.sv
// Multi-cycle floating-point square root, restoring digit recurrence, one root bit per cycle.
// Define FP_SQRT_ROUND_EN for round-to-nearest-even (extra ROUND cycle); default build truncates.
module fp_sqrt_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sqrt_start,
  input  logic [EXP_W+MAN_W:0] num_i,
  output logic                 busy_o,
  output logic [EXP_W+MAN_W:0] num_o,
  output logic                 error,
  output logic                 valid_o
);
  import fp_sqrt_pkg::*;

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int CNT_W = $clog2(MAN_W + 3);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(MAN_W + 1);
  localparam logic [EXP_W-1:0] BIAS_E  = EXP_W'(fp_bias(EXP_W));
  localparam logic [W-1:0]     QNAN    = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0]     INF     = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [EXP_W-1:0] exp_q;
  logic [EXP_W-1:0] res_exp;
  logic [MAN_W-1:0] frac_q;
  logic [MAN_W+3:0] rad;
  logic [MAN_W+3:0] rem;
  logic [MAN_W+1:0] root;

  logic is_zero, is_inf, is_nan, is_neg, is_special;
  logic [W-1:0] sp_res;
  logic         sp_err;

  fp_sqrt_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify (
    .num     (num_i),
    .is_zero (is_zero),
    .is_inf  (is_inf),
    .is_nan  (is_nan),
    .is_neg  (is_neg)
  );

  assign is_special = is_zero | is_inf | is_nan | is_neg;

  always_comb begin
    sp_res = INF;
    sp_err = 1'b0;
    if (is_nan)
      sp_res = QNAN;
    else if (is_zero)
      sp_res = {num_i[W-1], {(W-1){1'b0}}};
    else if (is_neg) begin
      sp_res = QNAN;
      sp_err = 1'b1;
    end
  end

  // floor((exp-bias)/2)+bias == (exp+bias)>>1; bit 0 of the sum is the parity of the unbiased exponent.
  logic [EXP_W:0] exp_sum;
  assign exp_sum = {1'b0, exp_q} + {1'b0, BIAS_E};

  logic [MAN_W+3:0] rem_sh, trial, rem_nxt;
  logic [MAN_W+1:0] root_nxt;

  always_comb begin
    rem_sh   = (MAN_W+4)'({rem, rad[MAN_W+3:MAN_W+2]});
    trial    = {root, 2'b01};
    rem_nxt  = rem_sh;
    root_nxt = {root[MAN_W:0], 1'b0};
    if (rem_sh >= trial) begin
      rem_nxt  = rem_sh - trial;
      root_nxt = {root[MAN_W:0], 1'b1};
    end
  end

`ifdef FP_SQRT_ROUND_EN
  logic             round_up;
  logic [MAN_W:0]   frac_rnd;
  logic [EXP_W-1:0] exp_rnd;

  always_comb begin
    round_up = root[0] & ((|rem) | root[1]);
    frac_rnd = {1'b0, root[MAN_W:1]} + {{MAN_W{1'b0}}, round_up};
    exp_rnd  = frac_rnd[MAN_W] ? res_exp + EXP_W'(1) : res_exp;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      error   <= 1'b0;
      num_o   <= '0;
      exp_q   <= '0;
      frac_q  <= '0;
      res_exp <= '0;
      rad     <= '0;
      rem     <= '0;
      root    <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sqrt_start) begin
            busy_o <= 1'b1;
            exp_q  <= num_i[W-2:MAN_W];
            frac_q <= num_i[MAN_W-1:0];
            if (is_special) begin
              num_o   <= sp_res;
              error   <= sp_err;
              valid_o <= 1'b1;
              state   <= S_DONE;
            end else begin
              state <= S_NORM;
            end
          end
        end
        S_NORM: begin
          // Radicand keeps the integer pair on top; odd exponents pre-double the significand.
          rad     <= exp_sum[0] ? {1'b1, frac_q, 3'b000} : {2'b01, frac_q, 2'b00};
          res_exp <= exp_sum[EXP_W:1];
          rem     <= '0;
          root    <= '0;
          cnt     <= '0;
          state   <= S_ITER;
        end
        S_ITER: begin
          rad  <= {rad[MAN_W+1:0], 2'b00};
          rem  <= rem_nxt;
          root <= root_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_IT) begin
`ifdef FP_SQRT_ROUND_EN
            state <= S_ROUND;
`else
            num_o   <= {1'b0, res_exp, root_nxt[MAN_W:1]};
            error   <= 1'b0;
            valid_o <= 1'b1;
            state   <= S_DONE;
`endif
          end
        end
`ifdef FP_SQRT_ROUND_EN
        S_ROUND: begin
          num_o   <= {1'b0, exp_rnd, frac_rnd[MAN_W-1:0]};
          error   <= 1'b0;
          valid_o <= 1'b1;
          state   <= S_DONE;
        end
`endif
        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqrt_param.sv
// Scoreboard bench for fp_sqrt_param: directed bfloat16 cases, ignored/back-to-back requests,
// mid-operation reset and a random sweep against an integer-sqrt reference model.
module tb_fp_sqrt_param;
  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam int W     = 1 + EXP_W + MAN_W;
`ifdef FP_SQRT_ROUND_EN
  localparam int LAT      = MAN_W + 4;
  localparam bit ROUND_EN = 1'b1;
`else
  localparam int LAT      = MAN_W + 3;
  localparam bit ROUND_EN = 1'b0;
`endif
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0] INF  = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sqrt_start;
  logic [W-1:0] num_i;
  logic         busy_o;
  logic [W-1:0] num_o;
  logic         error;
  logic         valid_o;

  fp_sqrt_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sqrt_start (sqrt_start),
    .num_i      (num_i),
    .busy_o     (busy_o),
    .num_o      (num_o),
    .error      (error),
    .valid_o    (valid_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           at;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned v);
    longint unsigned r, t;
    r = 0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  // Reference: sqrt of the real value, computed by integer square root on the scaled significand.
  function automatic void ref_sqrt(input logic [W-1:0] x, output logic [W-1:0] r,
                                   output logic er, output bit spc);
    int ex, e, re;
    longint unsigned fr, m, xs, q2, q;
    bit g, st;
    ex  = int'(x[W-2:MAN_W]);
    fr  = longint'(x[MAN_W-1:0]);
    er  = 1'b0;
    spc = 1'b1;
    r   = INF;
    if (ex == EMAX && fr != 0) r = QNAN;
    else if (ex == 0) r = {x[W-1], {(W-1){1'b0}}};
    else if (x[W-1]) begin
      r  = QNAN;
      er = 1'b1;
    end else if (ex == EMAX) r = INF;
    else begin
      spc = 1'b0;
      e   = ex - BIAS;
      m   = (64'd1 << MAN_W) | fr;
      if (e % 2 != 0) begin
        m = m * 2;
        e = e - 1;
      end
      re = e / 2 + BIAS;
      xs = m << (MAN_W + 2);
      q2 = isqrt(xs);
      g  = q2[0];
      st = (q2 * q2 != xs);
      q  = q2 >> 1;
      if (ROUND_EN && g && (st || q[0])) q = q + 1;
      if ((q >> (MAN_W + 1)) != 0) begin
        q  = q >> 1;
        re = re + 1;
      end
      r = {1'b0, EXP_W'(re), MAN_W'(q)};
    end
  endfunction

  task automatic issue_k(input logic [W-1:0] x, input logic [W-1:0] r, input logic er, input bit spc);
    int n = 0;
    exp_t ent;
    while (busy_o && n < 100) begin
      tick(1);
      n++;
    end
    chk("idle_before_issue", 64'(busy_o), 64'd0);
    ent.res = r;
    ent.err = er;
    ent.at  = cyc + 1 + (spc ? 0 : LAT);
    sb.push_back(ent);
    num_i      = x;
    sqrt_start = 1'b1;
    tick(1);
    sqrt_start = 1'b0;
    chk("accepted", 64'(busy_o), 64'd1);
  endtask

  task automatic issue(input logic [W-1:0] x);
    logic [W-1:0] r;
    logic er;
    bit spc;
    ref_sqrt(x, r, er, spc);
    issue_k(x, r, er, spc);
  endtask

  // Monitor: every valid_o pops one expectation and checks value, flag and arrival cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && valid_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got num_o=%0h want no result", num_o);
      end else begin
        e = sb.pop_front();
        chk("num_o", 64'(num_o), 64'(e.res));
        chk("error", 64'(error), 64'(e.err));
        chk("valid_cycle", 64'(cyc), 64'(e.at));
        chk("busy_with_valid", 64'(busy_o), 64'd1);
      end
    end
  end

  typedef struct {
    logic [15:0] x;
    logic [15:0] r;
    logic        er;
    bit          spc;
  } dir_t;

  dir_t dir[$] = '{
    '{16'h4080, 16'h4000, 1'b0, 1'b0},
    '{16'h4110, 16'h4040, 1'b0, 1'b0},
    '{16'h4000, 16'h3FB5, 1'b0, 1'b0},
    '{16'h3F80, 16'h3F80, 1'b0, 1'b0},
    '{16'hBF80, 16'h7FC0, 1'b1, 1'b1},
    '{16'h0000, 16'h0000, 1'b0, 1'b1},
    '{16'h8000, 16'h8000, 1'b0, 1'b1},
    '{16'h7F80, 16'h7F80, 1'b0, 1'b1},
    '{16'h7F81, 16'h7FC0, 1'b0, 1'b1},
    '{16'hFF80, 16'h7FC0, 1'b1, 1'b1},
    '{16'h0001, 16'h0000, 1'b0, 1'b1},
    '{16'h8005, 16'h8000, 1'b0, 1'b1}
  };

  initial begin
    rst_n      = 1'b0;
    sqrt_start = 1'b0;
    num_i      = '0;
    #2;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_num_o", 64'(num_o), 64'd0);
    tick(2);
    rst_n = 1'b1;

    foreach (dir[i]) issue_k(dir[i].x, dir[i].r, dir[i].er, dir[i].spc);

    // A request while busy must be dropped; the next one lands in the cycle after valid_o.
    issue(16'h4080);
    tick(2);
    num_i      = 16'h4110;
    sqrt_start = 1'b1;
    tick(1);
    sqrt_start = 1'b0;
    chk("busy_while_ignored", 64'(busy_o), 64'd1);
    issue_k(16'h3F80, 16'h3F80, 1'b0, 1'b0);
    issue_k(16'hBF80, 16'h7FC0, 1'b1, 1'b1);
    issue_k(16'h4000, 16'h3FB5, 1'b0, 1'b0);

    // Reset in the middle of the iteration phase aborts the operation without a result.
    issue(16'h4080);
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_num_o", 64'(num_o), 64'd0);
    chk("midrst_error", 64'(error), 64'd0);
    void'(sb.pop_back());
    tick(2);
    rst_n = 1'b1;
    issue_k(16'h4110, 16'h4040, 1'b0, 1'b0);

    for (int i = 0; i < 2500; i++) begin
      logic [W-1:0] x;
      if ($urandom_range(0, 3) == 0) x = W'($urandom);
      else x = {1'b0, EXP_W'($urandom_range(1, EMAX - 1)), MAN_W'($urandom)};
      issue(x);
    end

    for (int n = 0; n < 100 && sb.size() != 0; n++) tick(1);
    chk("drain", 64'(sb.size()), 64'd0);
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
